// File: rtl/branch_predictor_btb_if.sv
// Fetch lookup, execute feedback, redirect and statistics signals of the BTB.
interface branch_predictor_btb_if #(
  parameter int PC_SIZE = 16,
  parameter int STAT_W  = 16
);
  logic [PC_SIZE-1:0] lookup_pc;
  logic               predict_hit;
  logic               predict_taken;
  logic [PC_SIZE-1:0] predict_target;
  logic               fb_branch;
  logic [PC_SIZE-1:0] fb_pc;
  logic               fb_predict_taken;
  logic [PC_SIZE-1:0] fb_predict_target;
  logic               fb_feedback_taken;
  logic [PC_SIZE-1:0] fb_feedback_target;
  logic               redirect_valid;
  logic [PC_SIZE-1:0] redirect_pc;
  logic [STAT_W-1:0]  branch_count;
  logic [STAT_W-1:0]  mispredict_count;

  modport slave (
    input  lookup_pc, fb_branch, fb_pc, fb_predict_taken, fb_predict_target,
           fb_feedback_taken, fb_feedback_target,
    output predict_hit, predict_taken, predict_target, redirect_valid,
           redirect_pc, branch_count, mispredict_count
  );

  modport master (
    output lookup_pc, fb_branch, fb_pc, fb_predict_taken, fb_predict_target,
           fb_feedback_taken, fb_feedback_target,
    input  predict_hit, predict_taken, predict_target, redirect_valid,
           redirect_pc, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters, a one-cycle registered mispredict redirect and saturating stats.
module branch_predictor_btb #(
  parameter int PC_SIZE  = 16,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int PC_INC   = 1,
  parameter int STAT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_predictor_btb_if.slave  bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_SIZE - IDX_W;
  localparam logic [PC_SIZE-1:0]  PC_INC_V = PC_SIZE'(PC_INC);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WT   = CTR_BITS'(2 ** (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WNT  = CTR_BITS'(2 ** (CTR_BITS - 1) - 1);
  localparam logic [STAT_W-1:0]   STAT_MAX = '1;

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [PC_SIZE-1:0]  target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  logic                redirect_valid_q, redirect_valid_d;
  logic [PC_SIZE-1:0]  redirect_pc_q, redirect_pc_d;
  logic [STAT_W-1:0]   branch_count_q, branch_count_d;
  logic [STAT_W-1:0]   mispredict_count_q, mispredict_count_d;

  logic [IDX_W-1:0]    lk_idx, fb_idx;
  logic [TAG_W-1:0]    lk_tag, fb_tag;
  logic                lk_hit, fb_hit, mis;
  logic [CTR_BITS-1:0] fb_ctr_d;

  assign lk_idx = bus.lookup_pc[IDX_W-1:0];
  assign lk_tag = bus.lookup_pc[PC_SIZE-1:IDX_W];
  assign fb_idx = bus.fb_pc[IDX_W-1:0];
  assign fb_tag = bus.fb_pc[PC_SIZE-1:IDX_W];

  // Fetch-side lookup reads pre-update state; no bypass from a same-cycle update.
  always_comb begin
    lk_hit             = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    bus.predict_hit    = lk_hit;
    bus.predict_taken  = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
    bus.predict_target = bus.predict_taken ? target_q[lk_idx]
                                           : bus.lookup_pc + PC_INC_V;
  end

  // Mispredict detection and the trained counter value for the feedback entry.
  always_comb begin
    fb_hit = valid_q[fb_idx] && (tag_q[fb_idx] == fb_tag);
    mis    = (bus.fb_predict_taken != bus.fb_feedback_taken) ||
             (bus.fb_predict_taken && bus.fb_feedback_taken &&
              (bus.fb_predict_target != bus.fb_feedback_target));
    fb_ctr_d = ctr_q[fb_idx];
    if (bus.fb_feedback_taken) begin
      if (ctr_q[fb_idx] != CTR_MAX) fb_ctr_d = ctr_q[fb_idx] + CTR_BITS'(1);
    end else begin
      if (ctr_q[fb_idx] != '0) fb_ctr_d = ctr_q[fb_idx] - CTR_BITS'(1);
    end
  end

  // Next values for the redirect register and the saturating statistics.
  always_comb begin
    redirect_valid_d   = bus.fb_branch && mis;
    redirect_pc_d      = redirect_pc_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (redirect_valid_d)
      redirect_pc_d = bus.fb_feedback_taken ? bus.fb_feedback_target
                                            : bus.fb_pc + PC_INC_V;
    if (bus.fb_branch && branch_count_q != STAT_MAX)
      branch_count_d = branch_count_q + STAT_W'(1);
    if (redirect_valid_d && mispredict_count_q != STAT_MAX)
      mispredict_count_d = mispredict_count_q + STAT_W'(1);
  end

  // Table training; a taken miss evicts whatever occupies the index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (bus.fb_branch) begin
      if (fb_hit) begin
        ctr_q[fb_idx] <= fb_ctr_d;
        if (bus.fb_feedback_taken) target_q[fb_idx] <= bus.fb_feedback_target;
      end else if (bus.fb_feedback_taken) begin
        valid_q[fb_idx]  <= 1'b1;
        tag_q[fb_idx]    <= fb_tag;
        target_q[fb_idx] <= bus.fb_feedback_target;
        ctr_q[fb_idx]    <= CTR_WT;
      end
    end
  end

  // Redirect pulse and statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign bus.redirect_valid   = redirect_valid_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;
endmodule
